// File: rtl/ball_physics_if.sv
// ball_physics_if
// Groups the game-facing signals of ball_physics into one bundle.
//   paddle_one_y / paddle_two_y : top y of each paddle (driven by the controller side)
//   serve                       : level request to start play from IDLE or OVER
//   ball_x / ball_y             : top-left corner of the ball (to the graphics stage)
//   score_one / score_two       : player scores
//   point_one / point_two       : one-clock pulse when that player scores
//   state                       : IDLE=0, PLAY=1, SCORED=2, OVER=3
// Modports: master drives the paddles and serve, slave is the physics block.
interface ball_physics_if;
    logic [9:0] paddle_one_y;
    logic [9:0] paddle_two_y;
    logic       serve;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [3:0] score_one;
    logic [3:0] score_two;
    logic       point_one;
    logic       point_two;
    logic [1:0] state;

    modport master (
        output paddle_one_y, paddle_two_y, serve,
        input  ball_x, ball_y, score_one, score_two, point_one, point_two, state
    );

    modport slave (
        input  paddle_one_y, paddle_two_y, serve,
        output ball_x, ball_y, score_one, score_two, point_one, point_two, state
    );
endinterface

// File: rtl/ball_physics.sv
// ball_physics
// Pong ball motion, wall/paddle reflection, scoring and game state.
// The ball moves one pixel per axis on every motion tick (one clock in
// 2^TICK_BITS). After a miss the ball is parked at the center for
// HOLD_TICKS ticks, then play resumes toward the player who conceded,
// or the game ends once a score reaches WIN_SCORE.
// Ports:
//   clk50M : system clock, all registers on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : ball_physics_if slave modport (paddles, serve in; ball, scores,
//            point pulses, state out)
module ball_physics #(
    parameter int TICK_BITS  = 19,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int BALL_SIZE  = 8,
    parameter int PADDLE_W   = 8,
    parameter int PADDLE_H   = 64,
    parameter int P1_X       = 16,
    parameter int P2_X       = 616,
    parameter int HOLD_TICKS = 64,
    parameter int WIN_SCORE  = 9
) (
    input  logic          clk50M,
    input  logic          rst_n,
    ball_physics_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        SCORED = 2'd2,
        OVER   = 2'd3
    } state_t;

    localparam logic [9:0]  CENTER_X = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0]  CENTER_Y = 10'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [10:0] X_MAX    = 11'(SCREEN_W - BALL_SIZE);
    localparam logic [10:0] Y_MAX    = 11'(SCREEN_H - BALL_SIZE);
    localparam logic [10:0] P1_FACE  = 11'(P1_X + PADDLE_W);
    localparam logic [10:0] P2_FACE  = 11'(P2_X);
    localparam logic [10:0] BALL_EXT = 11'(BALL_SIZE);
    localparam logic [10:0] PAD_EXT  = 11'(PADDLE_H);
    localparam logic [3:0]  WIN      = 4'(WIN_SCORE);
    localparam int          HOLD_W   = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

    logic [TICK_BITS-1:0] tick_cnt;
    logic [HOLD_W-1:0]    hold_cnt;
    state_t               state_q;
    logic [9:0]           x_q, y_q;
    logic                 dx, dy;
    logic [3:0]           score_one_q, score_two_q;
    logic                 point_one_q, point_two_q;

    logic        tick;
    logic [10:0] x_ext, y_ext, pad_one_ext, pad_two_ext;
    logic        overlap_one, overlap_two;
    logic        hit_one, hit_two, miss_left, miss_right;
    logic        dx_next, dy_next;
    logic [9:0]  x_next, y_next;

    assign tick        = &tick_cnt;
    // Zero-extended copies so every bound comparison is 11-bit and cannot wrap
    assign x_ext       = {1'b0, x_q};
    assign y_ext       = {1'b0, y_q};
    assign pad_one_ext = {1'b0, bus.paddle_one_y};
    assign pad_two_ext = {1'b0, bus.paddle_two_y};
    assign overlap_one = (y_ext + BALL_EXT > pad_one_ext) && (y_ext < pad_one_ext + PAD_EXT);
    assign overlap_two = (y_ext + BALL_EXT > pad_two_ext) && (y_ext < pad_two_ext + PAD_EXT);

    // Next-tick motion: each axis flips when it meets its obstacle, then steps
    // one pixel in the (possibly new) direction. Misses only count if no paddle hit.
    always_comb begin
        hit_one    = !dx && (x_ext == P1_FACE) && overlap_one;
        hit_two    = dx && (x_ext + BALL_EXT == P2_FACE) && overlap_two;
        miss_left  = !dx && (x_ext == 11'd0) && !hit_one;
        miss_right = dx && (x_ext == X_MAX) && !hit_two;
        dx_next    = dx ^ (hit_one || hit_two);
        dy_next    = dy;
        if (!dy && (y_ext == 11'd0)) begin
            dy_next = 1'b1;
        end else if (dy && (y_ext == Y_MAX)) begin
            dy_next = 1'b0;
        end
        x_next = dx_next ? x_q + 10'd1 : x_q - 10'd1;
        y_next = dy_next ? y_q + 10'd1 : y_q - 10'd1;
    end

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt    <= '0;
            hold_cnt    <= '0;
            state_q     <= IDLE;
            x_q         <= CENTER_X;
            y_q         <= CENTER_Y;
            dx          <= 1'b1;
            dy          <= 1'b1;
            score_one_q <= 4'd0;
            score_two_q <= 4'd0;
            point_one_q <= 1'b0;
            point_two_q <= 1'b0;
        end else begin
            tick_cnt    <= tick_cnt + TICK_BITS'(1);
            point_one_q <= 1'b0;
            point_two_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    x_q <= CENTER_X;
                    y_q <= CENTER_Y;
                    if (bus.serve) begin
                        state_q <= PLAY;
                        dx      <= 1'b1;
                        dy      <= 1'b1;
                    end
                end
                PLAY: begin
                    if (tick) begin
                        if (miss_left || miss_right) begin
                            // Re-serve heads toward whoever conceded
                            state_q  <= SCORED;
                            hold_cnt <= '0;
                            x_q      <= CENTER_X;
                            y_q      <= CENTER_Y;
                            dx       <= miss_right;
                            dy       <= 1'b1;
                            if (miss_left) begin
                                point_two_q <= 1'b1;
                                if (score_two_q != WIN) score_two_q <= score_two_q + 4'd1;
                            end else begin
                                point_one_q <= 1'b1;
                                if (score_one_q != WIN) score_one_q <= score_one_q + 4'd1;
                            end
                        end else begin
                            x_q <= x_next;
                            y_q <= y_next;
                            dx  <= dx_next;
                            dy  <= dy_next;
                        end
                    end
                end
                SCORED: begin
                    x_q <= CENTER_X;
                    y_q <= CENTER_Y;
                    if (tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_cnt <= '0;
                            state_q  <= ((score_one_q == WIN) || (score_two_q == WIN)) ? OVER : PLAY;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                end
                OVER: begin
                    x_q <= CENTER_X;
                    y_q <= CENTER_Y;
                    if (bus.serve) begin
                        score_one_q <= 4'd0;
                        score_two_q <= 4'd0;
                        state_q     <= PLAY;
                        dx          <= 1'b1;
                        dy          <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ball_x    = x_q;
    assign bus.ball_y    = y_q;
    assign bus.score_one = score_one_q;
    assign bus.score_two = score_two_q;
    assign bus.point_one = point_one_q;
    assign bus.point_two = point_two_q;
    assign bus.state     = state_q;

endmodule
